mux_scan_n1: RTL and testbench

//  Parametrised registered N:1 channel multiplexer, successor to the fixed 8:1 bit mux.

---
 rtl/mux_scan_n1.sv | 129 ++++++++++++
 tb/tb_mux_scan_n1.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_n1.sv
// mux_scan_n1 -- registered N_CH:1 channel multiplexer with optional auto-scan.
//
// Picks one W-bit channel out of N_CH, either from the external select (mode=0)
// or from an internal scan pointer that advances after DWELL accepted samples
// (mode=1). The result is held in an output register behind a valid/ready
// handshake. While the consumer stalls, everything holds and en is ignored.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   data_in      N_CH*W packed channels, channel k at data_in[k*W +: W]
//   sel          manual channel select
//   mode         0 = manual, 1 = auto-scan
//   en           sample request; a load happens when en && !stall
//   out_data     registered channel data
//   out_ch       channel index that out_data came from
//   out_valid    out_data/out_ch valid
//   out_ready    consumer ready
//   sel_err      last load used an out-of-range manual select
module mux_scan_n1 #(
  parameter int N_CH  = 8,
  parameter int W     = 8,
  parameter int SEL_W = $clog2(N_CH),
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH*W-1:0]   data_in,
  input  logic [SEL_W-1:0]    sel,
  input  logic                mode,
  input  logic                en,
  output logic [W-1:0]        out_data,
  output logic [SEL_W-1:0]    out_ch,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                sel_err
);

  localparam int CW = $clog2(DWELL + 1);

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   scan_ptr_q, scan_ptr_d;
  logic [CW-1:0]      dwell_cnt_q, dwell_cnt_d;
  logic [W-1:0]       out_data_q, out_data_d;
  logic [SEL_W-1:0]   out_ch_q, out_ch_d;
  logic               out_valid_q, out_valid_d;
  logic               sel_err_q, sel_err_d;

  logic                   stall, load, ch_bad;
  logic [SEL_W-1:0]       ch;
  logic [W-1:0]           ch_data;
  logic [N_CH-1:0][W-1:0] ch_arr;

  // Unpack the flat channel bus into a per-channel array.
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ch_arr[k] = data_in[k*W +: W];
  end

  always_comb begin
    stall = out_valid_q && !out_ready;
    load  = en && !stall;

    state_d = mode ? SCAN : MANUAL;

    // On the first scan cycle the pointer is still at its manual-mode value
    // of zero, so entering SCAN always starts from channel 0.
    ch = mode ? ((state_q == SCAN) ? scan_ptr_q : '0) : sel;

    // Out-of-range selects match no channel and leave ch_data at zero.
    ch_data = '0;
    for (int k = 0; k < N_CH; k++)
      if (ch == SEL_W'(k)) ch_data = ch_arr[k];
    ch_bad = !mode && (32'(sel) >= N_CH);

    scan_ptr_d  = scan_ptr_q;
    dwell_cnt_d = dwell_cnt_q;
    if (!mode) begin
      scan_ptr_d  = '0;
      dwell_cnt_d = '0;
    end else if (load) begin
      if (dwell_cnt_q == CW'(DWELL - 1)) begin
        dwell_cnt_d = '0;
        scan_ptr_d  = (scan_ptr_q == SEL_W'(N_CH - 1)) ? '0 : scan_ptr_q + 1'b1;
      end else begin
        dwell_cnt_d = dwell_cnt_q + 1'b1;
      end
    end

    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    sel_err_d   = sel_err_q;
    if (load) begin
      out_data_d  = ch_data;
      out_ch_d    = ch;
      out_valid_d = 1'b1;
      sel_err_d   = ch_bad;
    end else if (!stall) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MANUAL;
      scan_ptr_q  <= '0;
      dwell_cnt_q <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_ptr_q  <= scan_ptr_d;
      dwell_cnt_q <= dwell_cnt_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_scan_n1.sv
// Bench for mux_scan_n1: an 8-channel instance driven against a reference
// model with a scoreboard queue, plus a 6-channel instance for the
// out-of-range select case.
module tb_mux_scan_n1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] data_in;
  logic [2:0]  sel;
  logic        mode, en, out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_valid, sel_err;

  logic [47:0] data6;
  logic [2:0]  sel6;
  logic        en6;
  logic [7:0]  out_data6;
  logic [2:0]  out_ch6;
  logic        out_valid6, sel_err6;

  always #5 clk = ~clk;

  mux_scan_n1 #(.N_CH(8), .W(8), .DWELL(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel(sel), .mode(mode),
    .en(en), .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err)
  );

  mux_scan_n1 #(.N_CH(6), .W(8), .SEL_W(3), .DWELL(4)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .data_in(data6), .sel(sel6), .mode(1'b0),
    .en(en6), .out_data(out_data6), .out_ch(out_ch6), .out_valid(out_valid6),
    .out_ready(1'b1), .sel_err(sel_err6)
  );

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state and scoreboard: {ch, data}
  logic        m_vld;
  int          m_ptr, m_cnt;
  logic [10:0] sb[$];
  logic [10:0] m_last;

  task automatic set_data(input logic [7:0] base);
    for (int k = 0; k < 8; k++) data_in[k*8 +: 8] = base + 8'(k);
  endtask

  task automatic model_reset();
    m_vld = 1'b0; m_ptr = 0; m_cnt = 0; m_last = '0;
    sb.delete();
  endtask

  task automatic step(input logic e, input logic m, input logic [2:0] s, input logic r);
    logic ld, stl;
    int   c;
    logic [10:0] exp;
    @(negedge clk);
    en = e; mode = m; sel = s; out_ready = r;
    stl = m_vld && !r;
    ld  = e && !stl;
    if (ld) begin
      c = m ? m_ptr : int'(s);
      sb.push_back({3'(c), data_in[c*8 +: 8]});
    end
    if (ld) m_vld = 1'b1;
    else if (!stl) m_vld = 1'b0;
    if (!m) begin
      m_ptr = 0; m_cnt = 0;
    end else if (ld) begin
      if (m_cnt == 3) begin
        m_cnt = 0;
        m_ptr = (m_ptr == 7) ? 0 : m_ptr + 1;
      end else m_cnt++;
    end
    @(posedge clk); #1;
    chk("valid", 32'(out_valid), 32'(m_vld));
    if (out_valid && ld) begin
      exp = sb.pop_front();
      m_last = exp;
      chk("data", 32'(out_data), 32'(exp[7:0]));
      chk("ch", 32'(out_ch), 32'(exp[10:8]));
      chk("err", 32'(sel_err), 32'd0);
    end else if (stl) begin
      chk("hold_data", 32'(out_data), 32'(m_last[7:0]));
      chk("hold_ch", 32'(out_ch), 32'(m_last[10:8]));
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 0; mode = 0; sel = 0; out_ready = 1;
    set_data(8'h10);
    for (int k = 0; k < 6; k++) data6[k*8 +: 8] = 8'h20 + 8'(k);
    sel6 = 0; en6 = 0;
    model_reset();
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    chk("rst_err", 32'(sel_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Manual select, then idle
    step(1, 0, 3'd5, 1);
    chk("man_data15", 32'(out_data), 32'h15);
    step(0, 0, 3'd5, 1);
    step(1, 0, 3'd2, 1);
    step(1, 0, 3'd7, 1);

    // Stall: data and sel change while held
    step(1, 0, 3'd3, 0);
    set_data(8'h40);
    step(1, 0, 3'd1, 0);
    set_data(8'h50);
    step(1, 0, 3'd6, 0);
    step(1, 0, 3'd4, 1);
    chk("stall_release", 32'(out_data), 32'h54);
    set_data(8'h10);

    // Scan: 33 loads, then a 2-cycle stall, then more
    step(0, 0, 3'd0, 1);
    for (int i = 0; i < 33; i++) step(1, 1, 3'd0, 1);
    chk("scan_wrap_ch", 32'(out_ch), 32'd0);
    for (int i = 0; i < 2; i++) step(1, 1, 3'd0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 3'd0, 1);
    chk("scan_after_stall", 32'(out_ch), 32'd2);

    // Mode switch at ch 3, count 2
    step(0, 0, 3'd0, 1);
    for (int i = 0; i < 14; i++) step(1, 1, 3'd0, 1);
    step(1, 0, 3'd6, 1);
    step(1, 1, 3'd0, 1);
    chk("restart_ch0", 32'(out_ch), 32'd0);
    for (int i = 0; i < 4; i++) step(1, 1, 3'd0, 1);
    chk("restart_ch1", 32'(out_ch), 32'd1);

    // Asynchronous reset mid-stream, away from any clock edge
    step(1, 0, 3'd4, 1);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_ch", 32'(out_ch), 32'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    step(0, 0, 3'd4, 1);
    step(0, 1, 3'd0, 1);
    step(1, 1, 3'd0, 1);

    // Out-of-range select on the 6-channel instance
    @(negedge clk); en6 = 1; sel6 = 3'd7;
    @(posedge clk); #1;
    chk("inv_valid", 32'(out_valid6), 32'd1);
    chk("inv_data", 32'(out_data6), 32'd0);
    chk("inv_ch", 32'(out_ch6), 32'd7);
    chk("inv_err", 32'(sel_err6), 32'd1);
    @(negedge clk); sel6 = 3'd2;
    @(posedge clk); #1;
    chk("ok_data", 32'(out_data6), 32'h22);
    chk("ok_ch", 32'(out_ch6), 32'd2);
    chk("ok_err", 32'(sel_err6), 32'd0);
    @(negedge clk); sel6 = 3'd6;
    @(posedge clk); #1;
    chk("inv6_err", 32'(sel_err6), 32'd1);
    chk("inv6_data", 32'(out_data6), 32'd0);
    @(negedge clk); en6 = 0;
    @(posedge clk); #1;
    chk("idle6_valid", 32'(out_valid6), 32'd0);
    chk("idle6_err_hold", 32'(sel_err6), 32'd1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
